// File: rtl/pipe_if_stage_pkg.sv
// rtl/pipe_if_stage_pkg.sv - shared encodings for the instruction-fetch stage
package pipe_if_stage_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } irq_state_e;

    // True for any control-transfer instruction whose successor is a delay slot.
    function automatic logic is_cti(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] funct;
        op    = inst[31:26];
        funct = inst[5:0];
        return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
               ((op == OP_SPECIAL) && (funct == FUNCT_JR));
    endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// rtl/pipe_ifid_reg.sv - IF/ID pipeline register with hold and bubble controls
module pipe_ifid_reg
    import pipe_if_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] inst_i,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc4_o,
    output logic [31:0] d_inst_o,
    output logic        d_valid_o
);

    logic [31:0] pc_q, pc4_q, inst_q;
    logic        valid_q;
    logic [31:0] pc_d, pc4_d, inst_d;
    logic        valid_d;

    // Bubble wins over hold so a flush is never swallowed by a stall.
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (bubble_i) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign d_pc_o    = pc_q;
    assign d_pc4_o   = pc4_q;
    assign d_inst_o  = inst_q;
    assign d_valid_o = valid_q;

endmodule

// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - fetch PC, next-PC arbitration, interrupt entry and IF/ID capture
module pipe_if_stage
    import pipe_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INTR_VEC = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        cancel,
    input  logic [31:0] cancel_pc,
    input  logic        intr,
    input  logic        ie,
    output logic        intr_ack,
    output logic [31:0] epc,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc4,
    output logic [31:0] d_inst,
    output logic        d_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    irq_state_e  state_q, state_d;
    logic [31:0] pc_plus4;
    logic [31:0] mux_pc;
    logic        d_is_cti;
    logic        take;

    assign pc_plus4 = pc_q + 32'd4;
    assign d_is_cti = d_valid && is_cti(d_inst);

    // Never take while the IF instruction is a delay slot; it would lose its branch.
    assign take = (state_q == ST_PEND) && !stall && !cancel && !d_is_cti;

    always_comb begin
        mux_pc = pc_plus4;
        case (pcsrc)
            PCSRC_SEQ: mux_pc = pc_plus4;
            PCSRC_BR:  mux_pc = bpc;
            PCSRC_JR:  mux_pc = rpc;
            PCSRC_J:   mux_pc = jpc;
            default:   mux_pc = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d  = mux_pc;
        epc_d = epc_q;
        if (cancel) begin
            pc_d = cancel_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (take) begin
            pc_d  = INTR_VEC;
            epc_d = pc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (intr && ie && !cancel) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (take || !ie) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end

    pipe_ifid_reg u_ifid (
        .clk_i     (clk),
        .rst_i     (rst),
        .hold_i    (stall && !cancel),
        .bubble_i  (cancel || take),
        .pc_i      (pc_q),
        .pc4_i     (pc_plus4),
        .inst_i    (inst),
        .d_pc_o    (d_pc),
        .d_pc4_o   (d_pc4),
        .d_inst_o  (d_inst),
        .d_valid_o (d_valid)
    );

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign intr_ack = take;

endmodule
